// File: rtl/dtb_pkg.sv
// dtb_pkg: shared sizes, stream FSM states and lane helpers for the trace front end
package dtb_pkg;
  localparam int TRB_WIDTH       = 64;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_NTRACE_BITS = 2;
  localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);
  localparam int TRB_CNT_BITS    = TRB_POS_BITS + 1;
  typedef enum logic [1:0] {EMPTY, WAIT, FULL} stream_state_e;
  function automatic logic [TRB_CNT_BITS-1:0] lanes(input logic [TRB_NTRACE_BITS-1:0] code);
    return TRB_CNT_BITS'(1) << code;
  endfunction
  function automatic logic [TRB_MAX_TRACES-1:0] lane_mask(input logic [TRB_NTRACE_BITS-1:0] code);
    return ~({TRB_MAX_TRACES{1'b1}} << lanes(code));
  endfunction
endpackage

// File: rtl/tracer.sv
// tracer: packs trace lanes into logger words, or serialises logger words back onto the lanes
module tracer
  import dtb_pkg::*;
(
  input  logic                       CLK_I,
  input  logic                       RST_NI,
  input  logic                       MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0]  TRACE_I,
  input  logic                       TRG_I,
  output logic [TRB_MAX_TRACES-1:0]  TRACE_O,
  output logic                       TRACE_VALID_O,
  output logic                       STORE_O,
  input  logic                       STORE_PERM_I,
  output logic [TRB_WIDTH-1:0]       DATA_O,
  output logic [TRB_POS_BITS-1:0]    EVENT_POS_O,
  output logic                       TRG_EVENT_O,
  input  logic                       TRG_DELAYED_I,
  output logic                       LOAD_REQUEST_O,
  input  logic                       LOAD_GRANT_I,
  input  logic [TRB_WIDTH-1:0]       DATA_I,
  output logic                       DROP_O
);
  logic                       mode_q, mode_d;
  logic [TRB_NTRACE_BITS-1:0] ntrace_q, ntrace_d;
  logic [TRB_CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [TRB_WIDTH-1:0]       shreg_q, shreg_d, pf_q, pf_d, data_q, data_d;
  stream_state_e              state_q, state_d;
  logic                       store_q, store_d, req_q, req_d, drop_q, drop_d, trg_q, trg_d;
  logic [TRB_POS_BITS-1:0]    pos_q, pos_d;
  logic                       chg, cap, last, drain;
  logic [TRB_CNT_BITS-1:0]    n;
  logic [TRB_MAX_TRACES-1:0]  mask;
  logic [TRB_WIDTH-1:0]       packed_w;

  // cnt_q counts packed bits in trace mode and bits still to shift out in stream mode
  always_comb begin
    n = lanes(ntrace_q);
    mask = lane_mask(ntrace_q);
    chg = MODE_I != mode_q || NTRACE_I != ntrace_q;
    cap = !mode_q && !chg && STORE_PERM_I && !TRG_DELAYED_I;
    last = cnt_q + n == TRB_CNT_BITS'(TRB_WIDTH);
    drain = state_q == FULL && cnt_q <= n;
    packed_w = shreg_q | (TRB_WIDTH'(TRACE_I & mask) << cnt_q);
    mode_d = MODE_I;
    ntrace_d = NTRACE_I;
    cnt_d = cnt_q;
    shreg_d = shreg_q;
    pf_d = pf_q;
    data_d = data_q;
    state_d = state_q;
    store_d = 1'b0;
    req_d = 1'b0;
    drop_d = drop_q || (!mode_q && !STORE_PERM_I && !TRG_DELAYED_I);
    trg_d = trg_q || (cap && TRG_I);
    pos_d = cap && TRG_I && !trg_q ? cnt_q[TRB_POS_BITS-1:0] : pos_q;
    if (chg) begin
      cnt_d = '0;
      shreg_d = '0;
      pf_d = '0;
      state_d = EMPTY;
    end else if (cap) begin
      cnt_d = last ? '0 : cnt_q + n;
      shreg_d = last ? '0 : packed_w;
      data_d = last ? packed_w : data_q;
      store_d = last;
    end else if (mode_q) begin
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - n;
      shreg_d = shreg_q >> n;
      req_d = state_q == EMPTY;
      pf_d = state_q == WAIT && LOAD_GRANT_I ? DATA_I : pf_q;
      state_d = state_q == EMPTY ? WAIT : state_q == WAIT && LOAD_GRANT_I ? FULL : drain ? EMPTY : state_q;
      if (drain) begin
        shreg_d = pf_q;
        cnt_d = TRB_CNT_BITS'(TRB_WIDTH);
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      mode_q <= 1'b0;
      ntrace_q <= '0;
      cnt_q <= '0;
      shreg_q <= '0;
      pf_q <= '0;
      data_q <= '0;
      state_q <= EMPTY;
      store_q <= 1'b0;
      req_q <= 1'b0;
      drop_q <= 1'b0;
      trg_q <= 1'b0;
      pos_q <= '0;
    end else begin
      mode_q <= mode_d;
      ntrace_q <= ntrace_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      pf_q <= pf_d;
      data_q <= data_d;
      state_q <= state_d;
      store_q <= store_d;
      req_q <= req_d;
      drop_q <= drop_d;
      trg_q <= trg_d;
      pos_q <= pos_d;
    end
  end

  assign TRACE_VALID_O = mode_q && cnt_q != '0;
  assign TRACE_O = TRACE_VALID_O ? shreg_q[TRB_MAX_TRACES-1:0] & mask : '0;
  assign STORE_O = store_q;
  assign DATA_O = data_q;
  assign EVENT_POS_O = pos_q;
  assign TRG_EVENT_O = trg_q;
  assign LOAD_REQUEST_O = req_q;
  assign DROP_O = drop_q;
endmodule

// File: tb/tb_tracer.sv
// tb_tracer: vector table, directed corner sequences and randomized runs against a bit-queue model
module tb_tracer;
  import dtb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mode, trg, perm, del, grant;
  logic [1:0] ntrace;
  logic [7:0] trace, trace_o;
  logic [63:0] data_i, data_o;
  logic [5:0] pos_o;
  logic valid_o, store_o, trg_o, req_o, drop_o;
  int n_checks = 0, n_errors = 0;
  bit m_mode, m_store, m_drop, m_trg, auto_grant;
  bit [1:0] m_code;
  bit m_bits[$];
  logic [63:0] m_data;
  int m_pos, grant_wait = -1, max_delay;
  logic [7:0] chunks[$];
  logic [63:0] words[$];

  typedef struct {
    logic [1:0] code; logic [7:0] tr; logic tg, pm, dl;
    logic st; logic [63:0] dat; logic drp, te; logic [5:0] pos;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tracer dut (
    .CLK_I(clk), .RST_NI(rst_n), .MODE_I(mode), .NTRACE_I(ntrace), .TRACE_I(trace), .TRG_I(trg),
    .TRACE_O(trace_o), .TRACE_VALID_O(valid_o), .STORE_O(store_o), .STORE_PERM_I(perm),
    .DATA_O(data_o), .EVENT_POS_O(pos_o), .TRG_EVENT_O(trg_o), .TRG_DELAYED_I(del),
    .LOAD_REQUEST_O(req_o), .LOAD_GRANT_I(grant), .DATA_I(data_i), .DROP_O(drop_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mode = 1'b0; ntrace = '0; trace = '0; trg = 1'b0; perm = 1'b1; del = 1'b0;
    grant = 1'b0; data_i = '0; auto_grant = 1'b0; max_delay = 0; grant_wait = -1;
    words.delete(); chunks.delete(); m_bits.delete();
    m_mode = 0; m_code = 0; m_store = 0; m_drop = 0; m_trg = 0; m_pos = 0; m_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // model: trace samples collected into a bit queue; stream words split into expected lane chunks
  task automatic tick();
    int n, gn;
    bit chg;
    logic [7:0] lm;
    @(posedge clk);
    #1;
    n = 1 << m_code;
    chg = mode != m_mode || ntrace != m_code;
    m_store = 0;
    if (!m_mode && !perm && !del) m_drop = 1;
    if (chg) begin
      m_bits.delete(); chunks.delete(); grant_wait = -1;
    end else if (!m_mode && perm && !del) begin
      if (trg && !m_trg) begin m_trg = 1; m_pos = m_bits.size(); end
      for (int i = 0; i < n; i++) m_bits.push_back(trace[i]);
      if (m_bits.size() == 64) begin
        for (int i = 0; i < 64; i++) m_data[i] = m_bits[i];
        m_store = 1;
        m_bits.delete();
      end
    end
    m_mode = mode; m_code = ntrace;
    chk("store", store_o, m_store);
    chk("data", data_o, m_data);
    chk("drop", drop_o, m_drop);
    chk("trg_event", trg_o, m_trg);
    chk("event_pos", pos_o, 64'(m_pos));
    if (valid_o && m_mode && chunks.size() != 0) chk("trace_o", trace_o, chunks.pop_front());
    else chk("trace_valid", valid_o, 0);
    if (auto_grant) begin
      grant = 1'b0;
      gn = 1 << ntrace;
      lm = 8'((16'd1 << gn) - 1);
      if (req_o) grant_wait = $urandom_range(max_delay, 0);
      if (grant_wait == 0) begin
        data_i = words.size() != 0 ? words.pop_front() : {$urandom, $urandom};
        grant = 1'b1;
        for (int i = 0; i < 64 / gn; i++) chunks.push_back(8'(data_i >> (i * gn)) & lm);
        grant_wait = -1;
      end else if (grant_wait > 0) grant_wait--;
      else if ($urandom_range(7, 0) == 0) begin
        grant = 1'b1;
        data_i = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    int at;
    bit found, req_seen;
    vecs.push_back('{2'd3, 8'h00, 0, 1, 0, 0, 64'h0, 0, 0, 6'd0});
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{2'd3, 8'(i), 0, 1, 0, i == 8, i == 8 ? 64'h0807060504030201 : 64'h0, 0, 0, 6'd0});
    vecs.push_back('{2'd3, 8'h55, 0, 1, 0, 0, 64'h0807060504030201, 0, 0, 6'd0});
    vecs.push_back('{2'd3, 8'h66, 1, 1, 0, 0, 64'h0807060504030201, 0, 1, 6'd8});
    vecs.push_back('{2'd3, 8'h77, 1, 1, 0, 0, 64'h0807060504030201, 0, 1, 6'd8});
    vecs.push_back('{2'd3, 8'h88, 1, 0, 1, 0, 64'h0807060504030201, 0, 1, 6'd8});
    vecs.push_back('{2'd3, 8'h99, 0, 0, 0, 0, 64'h0807060504030201, 1, 1, 6'd8});
    vecs.push_back('{2'd3, 8'hAA, 0, 1, 0, 0, 64'h0807060504030201, 1, 1, 6'd8});

    do_reset();
    chk("rst_store", store_o, 0); chk("rst_data", data_o, 0); chk("rst_pos", pos_o, 0);
    chk("rst_trg", trg_o, 0); chk("rst_drop", drop_o, 0); chk("rst_req", req_o, 0);
    chk("rst_valid", valid_o, 0); chk("rst_trace", trace_o, 0);

    foreach (vecs[i]) begin
      ntrace = vecs[i].code; trace = vecs[i].tr; trg = vecs[i].tg; perm = vecs[i].pm; del = vecs[i].dl;
      tick();
      chk("vec_store", store_o, vecs[i].st); chk("vec_data", data_o, vecs[i].dat);
      chk("vec_drop", drop_o, vecs[i].drp); chk("vec_trg", trg_o, vecs[i].te); chk("vec_pos", pos_o, vecs[i].pos);
    end

    do_reset();
    for (int k = 0; k < 64; k++) begin
      trace = (8'($urandom) & 8'hFE) | 8'(k & 1);
      tick();
    end
    chk("t1_store", store_o, 1); chk("t1_data", data_o, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    chk("t1_pulse", store_o, 0);

    do_reset();
    ntrace = 2'd2;
    tick();
    for (int k = 1; k <= 5; k++) begin
      trg = k == 5; trace = 8'($urandom);
      tick();
    end
    chk("t3_trg", trg_o, 1); chk("t3_pos", pos_o, 16);
    trg = 1'b1;
    repeat (3) tick();
    chk("t3_pos_sticky", pos_o, 16);

    do_reset();
    ntrace = 2'd3;
    tick();
    at = 0;
    for (int k = 1; k <= 20 && at == 0; k++) begin
      perm = !(k >= 4 && k <= 6); trace = 8'(k);
      tick();
      if (store_o) at = k;
    end
    chk("t4_latency", 64'(at), 11); chk("t4_data", data_o, 64'h0B0A_0908_0703_0201); chk("t4_drop", drop_o, 1);

    do_reset();
    for (int k = 0; k < 10; k++) begin trace = 8'($urandom); tick(); end
    ntrace = 2'd2; trace = 8'($urandom);
    tick();
    chk("t6_flush_nostore", store_o, 0);
    at = -1;
    for (int k = 0; k < 40 && at < 0; k++) begin
      trace = 8'hF0 | 8'(k);
      tick();
      if (store_o) at = k;
    end
    chk("t6_at", 64'(at), 15); chk("t6_data", data_o, 64'hFEDC_BA98_7654_3210);

    do_reset();
    for (int k = 0; k < 30; k++) begin trace = 8'($urandom); tick(); end
    do_reset();
    at = 0;
    for (int k = 1; k <= 80 && at == 0; k++) begin
      trace = 8'($urandom);
      tick();
      if (store_o) at = k;
    end
    chk("rst_mid_word", 64'(at), 64);

    do_reset();
    mode = 1'b1; ntrace = 2'd3; auto_grant = 1'b1; max_delay = 0;
    words.push_back(64'h1122_3344_5566_7788);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = valid_o; end
    chk("t5_start", found, 1);
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_valid", valid_o, 1); chk("t5_lane", trace_o, 8'h88 - 8'(8'h11 * i));
      req_seen |= req_o;
      tick();
    end
    chk("t5_req", req_seen, 1); chk("t5_gapfree", valid_o, 1);

    do_reset();
    for (int s = 0; s < 6; s++) begin
      if (s == 3) do_reset();
      ntrace = 2'($urandom);
      for (int c = 0; c < 300; c++) begin
        trace = 8'($urandom); trg = $urandom_range(40, 0) == 0;
        perm = $urandom_range(9, 0) != 0; del = $urandom_range(19, 0) == 0;
        if ($urandom_range(149, 0) == 0) ntrace = 2'($urandom);
        tick();
      end
    end

    do_reset();
    auto_grant = 1'b1; mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ntrace = 2'($urandom); max_delay = s * 4;
      for (int c = 0; c < 300; c++) begin
        trace = 8'($urandom); trg = $urandom_range(20, 0) == 0; perm = $urandom_range(9, 0) != 0;
        mode = $urandom_range(99, 0) != 0;
        if ($urandom_range(199, 0) == 0) ntrace = 2'($urandom);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
